vector_ls_sequencer: RTL

- Multi-slice vector load/store engine; successor to the single-slice vector LS register.
- Holds one vector buffer per slice and moves it to or from a scalar-width memory port word by word, under an internal FSM with valid/ready handshakes.
- Sits between the vector register file (a/y) and the core's data memory port.
- Replaces the externally sequenced word-select/serial-chain scheme.

---
 rtl/vector_ls_pkg.sv | 30 +++
 rtl/vector_ls_buffer.sv | 42 ++++
 rtl/vector_ls_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_ls_pkg.sv
// Shared types and helpers for the vector load/store sequencer.
//   - vector_t / scalar_t / vector_as_scalars_t : default-geometry data views
//   - state_t                                   : sequencer FSM states
//   - num_scalars()                             : memory words per vector
package vector_ls_pkg;

    localparam int NUM_ELEMS_DEF   = 8;
    localparam int ELEM_SIZE_DEF   = 16;
    localparam int SCALAR_SIZE_DEF = 32;
    localparam int VEC_DEF         = NUM_ELEMS_DEF * ELEM_SIZE_DEF;

    // Number of memory words that make up one vector.
    function automatic int num_scalars(input int vec_bits, input int scalar_bits);
        return vec_bits / scalar_bits;
    endfunction

    localparam int NUM_SCALARS_DEF = num_scalars(VEC_DEF, SCALAR_SIZE_DEF);

    typedef logic [VEC_DEF-1:0]                               vector_t;
    typedef logic [SCALAR_SIZE_DEF-1:0]                       scalar_t;
    typedef logic [NUM_SCALARS_DEF-1:0][SCALAR_SIZE_DEF-1:0]  vector_as_scalars_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/vector_ls_buffer.sv
// One slice's vector buffer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears the buffer)
//   cap_en      : load the whole vector from cap_data
//   cap_data    : whole-vector capture data
//   we          : write one memory word selected by sel_word with wdata
//   sel_word    : word index, word 0 in the LSBs
//   wdata       : word write data
//   q           : buffer contents
module vector_ls_buffer
    import vector_ls_pkg::*;
#(
    parameter int VEC         = 128,
    parameter int SCALAR_SIZE = 32,
    parameter int NUM_SCALARS = 4,
    parameter int WORD_W      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cap_en,
    input  logic [VEC-1:0]         cap_data,
    input  logic                   we,
    input  logic [WORD_W-1:0]      sel_word,
    input  logic [SCALAR_SIZE-1:0] wdata,
    output logic [VEC-1:0]         q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (cap_en) begin
            q <= cap_data;
        end else if (we) begin
            for (int w = 0; w < NUM_SCALARS; w++) begin
                if (sel_word == WORD_W'(w)) begin
                    q[w*SCALAR_SIZE +: SCALAR_SIZE] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/vector_ls_sequencer.sv
// Multi-slice vector load/store sequencer. Moves whole vector buffers to or
// from a scalar-width memory port one word at a time.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake (ready only while idle)
//   cmd_store                  : 1 = buffer->memory, 0 = memory->buffer
//   cmd_slice_mask             : participating slices
//   cmd_addr, cmd_stride       : base word address, word offset per slice
//   a                          : store source vectors (slice 0 in LSBs)
//   y                          : buffer contents (slice 0 in LSBs)
//   mem_req_valid/mem_req_ready: memory request handshake
//   mem_we, mem_addr, mem_wdata: registered request fields
//   mem_rsp_valid, mem_rdata   : load response
//   busy, done                 : not idle / one-cycle completion pulse
// Optional build macro VECTOR_LS_SEQUENCER_BYTE_SWAP_EN adds input swap_en,
// latched at accept; when set, memory words are byte-reversed both ways.
module vector_ls_sequencer
    import vector_ls_pkg::*;
#(
    parameter int NUM_SLICES  = 4,
    parameter int NUM_ELEMS   = 8,
    parameter int ELEM_SIZE   = 16,
    parameter int SCALAR_SIZE = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_store,
    input  logic [NUM_SLICES-1:0]                  cmd_slice_mask,
    input  logic [ADDR_WIDTH-1:0]                  cmd_addr,
    input  logic [ADDR_WIDTH-1:0]                  cmd_stride,
`ifdef VECTOR_LS_SEQUENCER_BYTE_SWAP_EN
    input  logic                                   swap_en,
`endif
    input  logic [NUM_SLICES*NUM_ELEMS*ELEM_SIZE-1:0] a,
    output logic [NUM_SLICES*NUM_ELEMS*ELEM_SIZE-1:0] y,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic                                   mem_we,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [SCALAR_SIZE-1:0]                 mem_wdata,
    input  logic                                   mem_rsp_valid,
    input  logic [SCALAR_SIZE-1:0]                 mem_rdata,
    output logic                                   busy,
    output logic                                   done
);

    localparam int VEC     = NUM_ELEMS * ELEM_SIZE;
    localparam int NSC     = num_scalars(VEC, SCALAR_SIZE);
    localparam int WORD_W  = (NSC > 1) ? $clog2(NSC) : 1;
    localparam int SLICE_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    state_t                  state_q, state_d;
    logic                    store_q, store_d;
    logic [NUM_SLICES-1:0]   mask_q, mask_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
    logic [SLICE_W-1:0]      slice_q, slice_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic                    req_valid_d, we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [SCALAR_SIZE-1:0]  wdata_d;

    logic                    accept;
    logic                    swap_cmd, swap_active;
    logic [SLICE_W-1:0]      first_slice, next_slice;
    logic                    has_next, last_word, finished;
    logic [SLICE_W-1:0]      adv_slice;
    logic [WORD_W-1:0]       adv_word;
    logic [NUM_SLICES-1:0]   cap_en, buf_we;
    logic [SCALAR_SIZE-1:0]  buf_wdata;

`ifdef VECTOR_LS_SEQUENCER_BYTE_SWAP_EN
    logic swap_q;
    always_ff @(posedge clk) begin
        if (reset)       swap_q <= 1'b0;
        else if (accept) swap_q <= swap_en;
    end
    assign swap_cmd    = swap_en;
    assign swap_active = swap_q;
`else
    assign swap_cmd    = 1'b0;
    assign swap_active = 1'b0;
`endif

    function automatic logic [SCALAR_SIZE-1:0] byte_rev(input logic [SCALAR_SIZE-1:0] x);
        logic [SCALAR_SIZE-1:0] r;
        r = '0;
        for (int b = 0; b < SCALAR_SIZE/8; b++) begin
            r[b*8 +: 8] = x[SCALAR_SIZE-8-b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [SCALAR_SIZE-1:0] word_of(
        input logic [NUM_SLICES*VEC-1:0] v,
        input logic [SLICE_W-1:0]        s,
        input logic [WORD_W-1:0]         w
    );
        return v[int'(s)*VEC + int'(w)*SCALAR_SIZE +: SCALAR_SIZE];
    endfunction

    // Address wraps naturally at ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [SLICE_W-1:0]    s,
        input logic [WORD_W-1:0]     w,
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] stride
    );
        return base + stride * ADDR_WIDTH'(s) + ADDR_WIDTH'(w);
    endfunction

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign buf_wdata = swap_active ? byte_rev(mem_rdata) : mem_rdata;

    // Lowest selected slice of the incoming command.
    always_comb begin
        first_slice = '0;
        for (int s = NUM_SLICES-1; s >= 0; s--) begin
            if (cmd_slice_mask[s]) first_slice = SLICE_W'(s);
        end
    end

    // Lowest selected slice above the current one.
    always_comb begin
        has_next   = 1'b0;
        next_slice = slice_q;
        for (int s = NUM_SLICES-1; s >= 0; s--) begin
            if (mask_q[s] && (s > int'(slice_q))) begin
                has_next   = 1'b1;
                next_slice = SLICE_W'(s);
            end
        end
    end

    assign last_word = (word_q == WORD_W'(NSC-1));
    assign finished  = last_word && !has_next;
    assign adv_slice = last_word ? next_slice : slice_q;
    assign adv_word  = last_word ? '0 : word_q + WORD_W'(1);

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        mask_d      = mask_q;
        base_d      = base_q;
        stride_d    = stride_q;
        slice_d     = slice_q;
        word_d      = word_q;
        req_valid_d = mem_req_valid;
        we_d        = mem_we;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        cap_en      = '0;
        buf_we      = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    store_d  = cmd_store;
                    mask_d   = cmd_slice_mask;
                    base_d   = cmd_addr;
                    stride_d = cmd_stride;
                    slice_d  = first_slice;
                    word_d   = '0;
                    if (cmd_store) cap_en = cmd_slice_mask;
                    if (cmd_slice_mask != '0) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        we_d        = cmd_store;
                        addr_d      = word_addr(first_slice, '0, cmd_addr, cmd_stride);
                        // Buffers capture on this same edge, so the first
                        // store word comes straight from a.
                        if (cmd_store) begin
                            wdata_d = swap_cmd ? byte_rev(word_of(a, first_slice, '0))
                                               : word_of(a, first_slice, '0);
                        end else begin
                            wdata_d = '0;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (store_q) begin
                        if (finished) begin
                            state_d     = DONE;
                            req_valid_d = 1'b0;
                            we_d        = 1'b0;
                        end else begin
                            slice_d = adv_slice;
                            word_d  = adv_word;
                            addr_d  = word_addr(adv_slice, adv_word, base_q, stride_q);
                            wdata_d = swap_active ? byte_rev(word_of(y, adv_slice, adv_word))
                                                  : word_of(y, adv_slice, adv_word);
                        end
                    end else begin
                        state_d     = WAIT_RSP;
                        req_valid_d = 1'b0;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    buf_we[slice_q] = 1'b1;
                    if (finished) begin
                        state_d = DONE;
                    end else begin
                        state_d     = REQ;
                        slice_d     = adv_slice;
                        word_d      = adv_word;
                        req_valid_d = 1'b1;
                        we_d        = 1'b0;
                        addr_d      = word_addr(adv_slice, adv_word, base_q, stride_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            store_q       <= 1'b0;
            mask_q        <= '0;
            base_q        <= '0;
            stride_q      <= '0;
            slice_q       <= '0;
            word_q        <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            mask_q        <= mask_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            slice_q       <= slice_d;
            word_q        <= word_d;
            mem_req_valid <= req_valid_d;
            mem_we        <= we_d;
            mem_addr      <= addr_d;
            mem_wdata     <= wdata_d;
        end
    end

    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        vector_ls_buffer #(
            .VEC         (VEC),
            .SCALAR_SIZE (SCALAR_SIZE),
            .NUM_SCALARS (NSC),
            .WORD_W      (WORD_W)
        ) u_buf (
            .clk      (clk),
            .reset    (reset),
            .cap_en   (cap_en[s]),
            .cap_data (a[s*VEC +: VEC]),
            .we       (buf_we[s]),
            .sel_word (word_q),
            .wdata    (buf_wdata),
            .q        (y[s*VEC +: VEC])
        );
    end

endmodule
